// File: rtl/bht_pkg.sv
// ============================================================================
//  Module      : bht_pkg
//  Description : Shared counter encodings and saturating-update helper for
//                the branch history table.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package bht_pkg;

    localparam logic [1:0] SNT       = 2'b00;
    localparam logic [1:0] WNT       = 2'b01;
    localparam logic [1:0] WT        = 2'b10;
    localparam logic [1:0] STT       = 2'b11;
    localparam logic [1:0] CNT_RESET = WT;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] w_next;
        if (taken) begin
            w_next = (cnt == STT) ? STT : cnt + 2'd1;
        end else begin
            w_next = (cnt == SNT) ? SNT : cnt - 2'd1;
        end
        return w_next;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bht_entry.sv
// ============================================================================
//  Module      : bht_entry
//  Description : One BHT row: valid, tag, target, 2-bit counter and age, with
//                the IF and EX tag compares.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bht_entry
    import bht_pkg::*;
#(
    parameter int TAG_BITS = 12,
    parameter int AGE_BITS = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [TAG_BITS-1:0] if_tag,
    input  logic [TAG_BITS-1:0] ex_tag,
    input  logic                ex_taken,
    input  logic [31:0]         ex_target,
    input  logic                train,
    input  logic                alloc,
    output logic                valid,
    output logic                if_hit,
    output logic                ex_hit,
    output logic                pred,
    output logic [31:0]         target,
    output logic [AGE_BITS-1:0] age
);

    localparam logic [AGE_BITS-1:0] c_age_one = AGE_BITS'(1);

    logic                r_valid;
    logic [TAG_BITS-1:0] r_tag;
    logic [31:0]         r_target;
    logic [1:0]          r_cnt;
    logic [AGE_BITS-1:0] r_age;

    assign if_hit = r_valid && (r_tag == if_tag);
    assign ex_hit = r_valid && (r_tag == ex_tag);
    assign valid  = r_valid;
    assign pred   = r_cnt[1];
    assign target = r_target;
    assign age    = r_age;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid  <= 1'b0;
            r_tag    <= '0;
            r_target <= '0;
            r_cnt    <= CNT_RESET;
            r_age    <= '0;
        end else if (alloc) begin
            r_valid  <= 1'b1;
            r_tag    <= ex_tag;
            r_target <= ex_target;
            r_cnt    <= CNT_RESET;
            r_age    <= '0;
        end else if (train && ex_hit) begin
            r_cnt <= sat_update(r_cnt, ex_taken);
            if (ex_taken) begin
                r_target <= ex_target;
            end
            r_age <= '0;
        end else if (r_valid) begin
            // Recently fetched rows stay young; idle rows age toward eviction.
            if (if_hit) begin
                r_age <= '0;
            end else if (r_age != '1) begin
                r_age <= r_age + c_age_one;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bht_table.sv
// ============================================================================
//  Module      : bht_table
//  Description : Fully associative branch history table with age-based victim
//                selection. Optional counters enabled by BHT_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bht_table
    import bht_pkg::*;
#(
    parameter int ENTRIES  = 8,
    parameter int TAG_BITS = 12,
    parameter int AGE_BITS = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] if_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target
`ifdef BHT_STATS_EN
    ,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_mispred
`endif
);

    localparam int c_idx_w = $clog2(ENTRIES);

    logic [ENTRIES-1:0]  w_valid;
    logic [ENTRIES-1:0]  w_if_hit;
    logic [ENTRIES-1:0]  w_ex_hit;
    logic [ENTRIES-1:0]  w_pred;
    logic [ENTRIES-1:0]  w_alloc;
    logic [31:0]         w_target [ENTRIES];
    logic [AGE_BITS-1:0] w_age    [ENTRIES];

    logic                w_train;
    logic                w_ex_any;
    logic                w_do_alloc;
    logic [c_idx_w-1:0]  w_victim;
    logic                w_free_found;
    logic [AGE_BITS-1:0] w_max_age;
    logic                w_unused;

    assign w_unused   = ^{if_pc[31:TAG_BITS], ex_pc[31:TAG_BITS]};
    assign w_train    = ex_branch && !flush;
    assign w_ex_any   = |w_ex_hit;
    assign w_do_alloc = ex_branch && ex_taken && !w_ex_any && !flush;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_row
        assign w_alloc[g] = w_do_alloc && (w_victim == c_idx_w'(g));

        bht_entry #(
            .TAG_BITS (TAG_BITS),
            .AGE_BITS (AGE_BITS)
        ) u_entry (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .if_tag    (if_pc[TAG_BITS-1:0]),
            .ex_tag    (ex_pc[TAG_BITS-1:0]),
            .ex_taken  (ex_taken),
            .ex_target (ex_target),
            .train     (w_train),
            .alloc     (w_alloc[g]),
            .valid     (w_valid[g]),
            .if_hit    (w_if_hit[g]),
            .ex_hit    (w_ex_hit[g]),
            .pred      (w_pred[g]),
            .target    (w_target[g]),
            .age       (w_age[g])
        );
    end

    // Free rows first; otherwise the oldest row, strict '>' keeps lowest index on ties.
    always_comb begin
        w_victim     = '0;
        w_free_found = 1'b0;
        w_max_age    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!w_valid[i] && !w_free_found) begin
                w_victim     = c_idx_w'(i);
                w_free_found = 1'b1;
            end
        end
        if (!w_free_found) begin
            w_max_age = w_age[0];
            for (int i = 1; i < ENTRIES; i++) begin
                if (w_age[i] > w_max_age) begin
                    w_max_age = w_age[i];
                    w_victim  = c_idx_w'(i);
                end
            end
        end
    end

    always_comb begin
        pred_hit    = |w_if_hit;
        pred_taken  = 1'b0;
        pred_target = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_if_hit[i]) begin
                pred_taken  = w_pred[i];
                pred_target = w_target[i];
            end
        end
    end

`ifdef BHT_STATS_EN
    logic        w_ex_pred;
    logic        w_mispred;
    logic [31:0] r_lookups;
    logic [31:0] r_hits;
    logic [31:0] r_mispred;

    always_comb begin
        w_ex_pred = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_ex_hit[i]) begin
                w_ex_pred = w_pred[i];
            end
        end
    end

    assign w_mispred = ex_branch && ((w_ex_any && (w_ex_pred != ex_taken)) ||
                                     (!w_ex_any && ex_taken));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lookups <= '0;
            r_hits    <= '0;
            r_mispred <= '0;
        end else begin
            r_lookups <= r_lookups + 32'd1;
            if (pred_hit) begin
                r_hits <= r_hits + 32'd1;
            end
            if (w_mispred) begin
                r_mispred <= r_mispred + 32'd1;
            end
        end
    end

    assign stat_lookups = r_lookups;
    assign stat_hits    = r_hits;
    assign stat_mispred = r_mispred;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bht_table.sv
// ============================================================================
//  Module      : tb_bht_table
//  Description : Self-checking bench for bht_table (vector table, corner
//                sequences, randomized run against a reference model).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bht_table;

    logic        clk = 1'b0;
    logic        rst, flush, ex_branch, ex_taken;
    logic [31:0] if_pc, ex_pc, ex_target;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
`ifdef BHT_STATS_EN
    logic [31:0] stat_lookups, stat_hits, stat_mispred;
`endif

    always #5 clk = ~clk;

    bht_table #(.ENTRIES(8), .TAG_BITS(12), .AGE_BITS(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .if_pc        (if_pc),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .ex_branch    (ex_branch),
        .ex_pc        (ex_pc),
        .ex_taken     (ex_taken),
        .ex_target    (ex_target)
`ifdef BHT_STATS_EN
        ,
        .stat_lookups (stat_lookups),
        .stat_hits    (stat_hits),
        .stat_mispred (stat_mispred)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: table as plain arrays, next state from the behavioural rules.
    bit          m_valid [8];
    int unsigned m_tag   [8];
    logic [31:0] m_tgt   [8];
    int          m_cnt   [8];
    int          m_age   [8];
    logic [31:0] m_look, m_hits, m_misp;

    function automatic int m_find(input logic [31:0] pc);
        for (int i = 0; i < 8; i++)
            if (m_valid[i] && m_tag[i] == int'(pc[11:0])) return i;
        return -1;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 2; m_age[i] = 0;
        end
    endtask

    task automatic m_step();
        int ih, eh, vic, best;
        if (rst) begin
            m_clear();
            m_look = 0; m_hits = 0; m_misp = 0;
            return;
        end
        ih = m_find(if_pc);
        eh = ex_branch ? m_find(ex_pc) : -1;
        m_look++;
        if (ih >= 0) m_hits++;
        if (ex_branch && ((eh >= 0 && ((m_cnt[eh] >= 2) != ex_taken)) || (eh < 0 && ex_taken)))
            m_misp++;
        if (flush) begin
            m_clear();
            return;
        end
        vic = -1;
        if (ex_branch && eh < 0 && ex_taken) begin
            for (int i = 0; i < 8 && vic < 0; i++) if (!m_valid[i]) vic = i;
            if (vic < 0) begin
                best = -1;
                for (int i = 0; i < 8; i++)
                    if (m_age[i] > best) begin best = m_age[i]; vic = i; end
            end
        end
        for (int i = 0; i < 8; i++)
            if (m_valid[i])
                m_age[i] = (i == ih || i == eh || i == vic) ? 0 : ((m_age[i] + 1 > 32767) ? 32767 : m_age[i] + 1);
        if (eh >= 0) begin
            m_cnt[eh] = ex_taken ? ((m_cnt[eh] == 3) ? 3 : m_cnt[eh] + 1)
                                 : ((m_cnt[eh] == 0) ? 0 : m_cnt[eh] - 1);
            if (ex_taken) m_tgt[eh] = ex_target;
        end
        if (vic >= 0) begin
            m_valid[vic] = 1; m_tag[vic] = int'(ex_pc[11:0]); m_tgt[vic] = ex_target;
            m_cnt[vic] = 2; m_age[vic] = 0;
        end
    endtask

    task automatic drive(input bit fl, input logic [31:0] ipc, input bit exb,
                         input logic [31:0] epc, input bit ext, input logic [31:0] etg);
        rst = 0; flush = fl; if_pc = ipc; ex_branch = exb; ex_pc = epc; ex_taken = ext; ex_target = etg;
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit mchk);
        int ih;
        #2;
        if (mchk) begin
            ih = m_find(if_pc);
            chk("rnd_hit",    {31'd0, pred_hit},   {31'd0, ih >= 0});
            chk("rnd_taken",  {31'd0, pred_taken}, {31'd0, ih >= 0 && m_cnt[ih] >= 2});
            chk("rnd_target", pred_target,         ih >= 0 ? m_tgt[ih] : 32'd0);
`ifdef BHT_STATS_EN
            chk("rnd_lookups", stat_lookups, m_look);
            chk("rnd_hits",    stat_hits,    m_hits);
            chk("rnd_mispred", stat_mispred, m_misp);
`endif
        end
        tick();
    endtask

    task automatic do_reset();
        drive(0, 32'h100, 0, 0, 0, 0);
        rst = 1;
        step(0);
        rst = 0;
    endtask

    typedef struct {
        bit          fl;
        logic [31:0] ipc;
        bit          exb;
        logic [31:0] epc;
        bit          ext;
        logic [31:0] etg;
        bit          e_hit;
        bit          e_taken;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t tbl [17];

    initial begin
        tbl[0]  = '{0, 32'h100, 0, 32'h0,  0, 32'h0,  0, 0, 32'h0};
        tbl[1]  = '{0, 32'h100, 1, 32'h40, 1, 32'h80, 0, 0, 32'h0};
        tbl[2]  = '{0, 32'h40,  0, 32'h0,  0, 32'h0,  1, 1, 32'h80};
        tbl[3]  = '{0, 32'h40,  1, 32'h40, 0, 32'h0,  1, 1, 32'h80};
        tbl[4]  = '{0, 32'h40,  1, 32'h40, 0, 32'h0,  1, 0, 32'h80};
        tbl[5]  = '{0, 32'h40,  1, 32'h40, 1, 32'h90, 1, 0, 32'h80};
        tbl[6]  = '{0, 32'h40,  1, 32'h40, 1, 32'h90, 1, 0, 32'h90};
        tbl[7]  = '{0, 32'h40,  1, 32'h40, 1, 32'h90, 1, 1, 32'h90};
        tbl[8]  = '{0, 32'h40,  1, 32'h40, 1, 32'h90, 1, 1, 32'h90};
        tbl[9]  = '{0, 32'h40,  1, 32'h40, 0, 32'h0,  1, 1, 32'h90};
        tbl[10] = '{0, 32'h40,  0, 32'h0,  0, 32'h0,  1, 1, 32'h90};
        tbl[11] = '{0, 32'h44,  0, 32'h0,  0, 32'h0,  0, 0, 32'h0};
        tbl[12] = '{0, 32'h100, 1, 32'h44, 0, 32'h0,  0, 0, 32'h0};
        tbl[13] = '{0, 32'h44,  0, 32'h0,  0, 32'h0,  0, 0, 32'h0};
        tbl[14] = '{1, 32'h40,  1, 32'h50, 1, 32'h60, 1, 1, 32'h90};
        tbl[15] = '{0, 32'h40,  0, 32'h0,  0, 32'h0,  0, 0, 32'h0};
        tbl[16] = '{0, 32'h50,  0, 32'h0,  0, 32'h0,  0, 0, 32'h0};

        do_reset();

        // Vector table: allocate, train, simultaneous IF/EX, no-alloc miss, flush.
        for (int v = 0; v < 17; v++) begin
            drive(tbl[v].fl, tbl[v].ipc, tbl[v].exb, tbl[v].epc, tbl[v].ext, tbl[v].etg);
            #2;
            chk($sformatf("vec%0d_hit", v),    {31'd0, pred_hit},   {31'd0, tbl[v].e_hit});
            chk($sformatf("vec%0d_taken", v),  {31'd0, pred_taken}, {31'd0, tbl[v].e_taken});
            chk($sformatf("vec%0d_target", v), pred_target,         tbl[v].e_tgt);
            tick();
        end

        // Replacement: fill 0x00..0x1C, refresh all but 0x08, then allocate 0x20.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(0, 32'hFFC, 1, 32'(k * 4), 1, 32'(32'h200 + k));
            step(0);
        end
        for (int k = 0; k < 8; k++) begin
            if (k == 2) continue;
            drive(0, 32'(k * 4), 0, 0, 0, 0);
            step(0);
        end
        drive(0, 32'hFFC, 1, 32'h20, 1, 32'h300);
        step(0);
        for (int k = 0; k < 9; k++) begin
            drive(0, 32'(k * 4), 0, 0, 0, 0);
            #2;
            chk($sformatf("repl_hit_%0h", k * 4), {31'd0, pred_hit}, {31'd0, k != 2});
            if (k != 2)
                chk($sformatf("repl_tgt_%0h", k * 4), pred_target,
                    (k == 8) ? 32'h300 : 32'(32'h200 + k));
            tick();
        end

`ifdef BHT_STATS_EN
        // Hits survive flush, cleared by reset.
        do_reset();
        drive(0, 32'hFFC, 1, 32'h40, 1, 32'h80);
        step(0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 32'h40, 0, 0, 0, 0);
            step(0);
        end
        drive(1, 32'hFFC, 0, 0, 0, 0);
        step(0);
        drive(0, 32'hFFC, 0, 0, 0, 0);
        #2;
        chk("stat_hits_after_flush", stat_hits, 32'd3);
        chk("stat_lookups_after_flush", stat_lookups, 32'd5);
        chk("stat_mispred_alloc", stat_mispred, 32'd1);
        tick();
        rst = 1;
        step(0);
        rst = 0;
        #2;
        chk("stat_hits_after_rst", stat_hits, 32'd0);
        chk("stat_lookups_after_rst", stat_lookups, 32'd0);
        tick();
`endif

        // Randomized run against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            logic [31:0] ipc, epc;
            r   = $urandom_range(0, 199);
            ipc = 32'($urandom_range(0, 15) * 4) | (($urandom_range(0, 9) == 0) ? 32'h1000 : 32'h0);
            epc = 32'($urandom_range(0, 15) * 4);
            drive(r >= 1 && r < 4, ipc, $urandom_range(0, 1) == 1, epc,
                  $urandom_range(0, 9) < 6, $urandom);
            rst = (r == 0);
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
